// File: rtl/l1c_refill_arb.sv
// Shares one AXI-style read master between the I-cache and D-cache refill paths.
// Latency: arvalid 1 cycle after a request is seen in IDLE; beat outputs 1 cycle after each rvalid&rready.
// Backpressure: arvalid held until arready; rready is high for the whole DATA phase, so rvalid gaps just stall the burst.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   i_req/i_addr, d_req/d_addr      refill requests (level, held until *_done) and miss addresses
//   i_rvalid/i_beat/i_done          per-beat strobe, beat index and last-beat flag to the I-cache
//   d_rvalid/d_beat/d_done          same for the D-cache
//   rdata_o, rerr_o                 registered beat data and per-beat error, shared by both owners
//   araddr/arlen/arvalid/arready    AR channel (line-aligned address, fixed burst length)
//   rdata/rresp/rlast/rvalid/rready R channel
//   prot_err                        sticky: rlast disagreed with the beat counter
//
// Build option: define REFILL_ARB_RR_EN for round-robin arbitration when both caches
// request at once; otherwise the D-cache always wins a tie.

module l1c_refill_arb #(
  parameter int BURST_LEN = 4,
  parameter int OFFS_BITS = $clog2(BURST_LEN*4)
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic                         i_req,
  input  logic [31:0]                  i_addr,
  output logic                         i_rvalid,
  output logic [$clog2(BURST_LEN)-1:0] i_beat,
  output logic                         i_done,

  input  logic                         d_req,
  input  logic [31:0]                  d_addr,
  output logic                         d_rvalid,
  output logic [$clog2(BURST_LEN)-1:0] d_beat,
  output logic                         d_done,

  output logic [31:0]                  rdata_o,
  output logic                         rerr_o,

  output logic [31:0]                  araddr,
  output logic [3:0]                   arlen,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [31:0]                  rdata,
  input  logic [1:0]                   rresp,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready,

  output logic                         prot_err
);

  localparam int              BW        = $clog2(BURST_LEN);
  localparam logic [BW-1:0]   LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [31:0]     ADDR_MASK = ~((32'd1 << OFFS_BITS) - 32'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t         state_q;
  logic           owner_q;      // 1 = D-cache owns the current burst
  logic [BW-1:0]  cnt_q;
  logic [31:0]    araddr_q;
  logic           arvalid_q;
  logic           rready_q;
  logic           i_rvalid_q, d_rvalid_q;
  logic           i_done_q, d_done_q;
  logic [BW-1:0]  i_beat_q, d_beat_q;
  logic [31:0]    rdata_q;
  logic           rerr_q;
  logic           prot_err_q;

  logic           owner_d;
  logic [31:0]    grant_addr;
  logic           last_beat;

`ifdef REFILL_ARB_RR_EN
  // Which side wins the next tie; flips to the other side on every grant.
  logic           rr_favor_d_q;
`endif

  // A lone request always wins; only a tie consults the arbitration policy.
  always_comb begin
    owner_d = d_req;
`ifdef REFILL_ARB_RR_EN
    if (i_req && d_req) owner_d = rr_favor_d_q;
`endif
  end

  assign grant_addr = owner_d ? d_addr : i_addr;
  assign last_beat  = (cnt_q == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      i_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      i_beat_q     <= '0;
      d_beat_q     <= '0;
      rdata_q      <= '0;
      rerr_q       <= 1'b0;
      prot_err_q   <= 1'b0;
`ifdef REFILL_ARB_RR_EN
      rr_favor_d_q <= 1'b1;
`endif
    end else begin
      // Beat strobes are single-cycle pulses.
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      rerr_q     <= 1'b0;

      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            owner_q      <= owner_d;
            araddr_q     <= grant_addr & ADDR_MASK;
            cnt_q        <= '0;
            arvalid_q    <= 1'b1;
            state_q      <= ADDR;
`ifdef REFILL_ARB_RR_EN
            rr_favor_d_q <= ~owner_d;
`endif
          end
        end

        ADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= DATA;
          end
        end

        DATA: begin
          if (rvalid) begin
            if (owner_q) begin
              d_rvalid_q <= 1'b1;
              d_beat_q   <= cnt_q;
              d_done_q   <= last_beat;
            end else begin
              i_rvalid_q <= 1'b1;
              i_beat_q   <= cnt_q;
              i_done_q   <= last_beat;
            end
            rdata_q <= rdata;
            rerr_q  <= |rresp;
            // The counter, not rlast, decides completion; a mismatch is only flagged.
            if (last_beat != rlast) prot_err_q <= 1'b1;
            cnt_q <= cnt_q + BW'(1);
            if (last_beat) begin
              rready_q <= 1'b0;
              state_q  <= IDLE;
            end
          end
        end

        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign i_rvalid = i_rvalid_q;
  assign i_beat   = i_beat_q;
  assign i_done   = i_done_q;
  assign d_rvalid = d_rvalid_q;
  assign d_beat   = d_beat_q;
  assign d_done   = d_done_q;
  assign rdata_o  = rdata_q;
  assign rerr_o   = rerr_q;
  assign araddr   = araddr_q;
  assign arlen    = 4'(BURST_LEN - 1);
  assign arvalid  = arvalid_q;
  assign rready   = rready_q;
  assign prot_err = prot_err_q;

endmodule

// File: tb/tb_l1c_refill_arb.sv
// Directed bench for l1c_refill_arb (BURST_LEN = 4).
// Inputs change and outputs are sampled on the falling clock edge.
// Each scenario task checks its own results against hand-computed values.

module tb_l1c_refill_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr;
  logic        i_rvalid, d_rvalid, i_done, d_done;
  logic [1:0]  i_beat, d_beat;
  logic [31:0] rdata_o;
  logic        rerr_o;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        prot_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations gathered by run_burst
  int          n_beats, arv_cnt, first_arv, done_cyc, stray, early_beat;
  logic        got_done, araddr_chg;
  logic [31:0] obs_araddr;
  logic [1:0]  obs_own  [16];
  int          obs_beat [16];
  logic [31:0] obs_data [16];
  logic        obs_err  [16];
  logic [1:0]  obs_done [16];
  logic        obs_prot [16];

  l1c_refill_arb dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_beat(i_beat), .i_done(i_done),
    .d_req(d_req), .d_addr(d_addr), .d_rvalid(d_rvalid), .d_beat(d_beat), .d_done(d_done),
    .rdata_o(rdata_o), .rerr_o(rerr_o),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .prot_err(prot_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Acts as the AXI slave for one burst and records what the owner sees.
  // The request must already be driven. Outside DATA the bench drives junk on
  // the R channel (rvalid=1, rlast=1, rresp=3) that the DUT must ignore.
  task automatic run_burst(input int ar_wait, input logic [7:0] rv_pat, input int rv_len,
                           input int err_beat, input logic [3:0] last_mask,
                           input logic [31:0] dbase);
    int   k, pi, arc;
    logic v;
    n_beats = 0; got_done = 0; arv_cnt = 0; araddr_chg = 0; early_beat = 0;
    stray = 0; first_arv = -1; done_cyc = -1; obs_araddr = '0;
    k = 0; pi = 0; arc = 0;
    for (int cyc = 0; cyc < 100 && !got_done; cyc++) begin
      @(negedge clk);
      if (i_rvalid || d_rvalid) begin
        if (n_beats < 16) begin
          obs_own[n_beats]  = {i_rvalid, d_rvalid};
          obs_beat[n_beats] = d_rvalid ? int'(d_beat) : int'(i_beat);
          obs_data[n_beats] = rdata_o;
          obs_err[n_beats]  = rerr_o;
          obs_done[n_beats] = {i_done, d_done};
          obs_prot[n_beats] = prot_err;
        end
        n_beats++;
        if (arvalid) early_beat++;
        if (i_done || d_done) begin
          got_done = 1'b1;
          done_cyc = cyc;
        end
      end else if (i_done || d_done) begin
        stray++;
      end
      if (arvalid) begin
        if (arv_cnt == 0) begin
          first_arv  = cyc;
          obs_araddr = araddr;
        end else if (araddr !== obs_araddr) begin
          araddr_chg = 1'b1;
        end
        arv_cnt++;
      end
      if (!got_done) begin
        arready = arvalid && (arc >= ar_wait);
        if (arvalid) arc++;
        if (rready) begin
          v = (pi < rv_len) ? rv_pat[pi] : 1'b1;
          pi++;
          if (v && k < 4) begin
            rvalid = 1'b1;
            rdata  = dbase + 32'(k);
            rresp  = (k == err_beat) ? 2'd2 : 2'd0;
            rlast  = last_mask[k];
            k++;
          end else begin
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
          end
        end else begin
          rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'd3; rlast = 1'b1;
        end
      end
    end
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
  endtask

  task automatic test_reset();
    logic [11:0] ctl;
    rst = 1'b1;
    i_req = 0; d_req = 0; i_addr = '0; d_addr = '0;
    arready = 0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
    @(negedge clk);
    ctl = {arvalid, rready, i_rvalid, d_rvalid, i_done, d_done, i_beat, d_beat, rerr_o, prot_err};
    n_tests++;
    if (ctl !== 12'h000) begin n_fail++; $display("FAIL reset_ctl: got %h expected %h", ctl, 12'h000); end
    n_tests++;
    if (araddr !== 32'h0) begin n_fail++; $display("FAIL reset_araddr: got %h expected 0", araddr); end
    n_tests++;
    if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata_o); end
    n_tests++;
    if (arlen !== 4'd3) begin n_fail++; $display("FAIL reset_arlen: got %0d expected 3", arlen); end
    rst = 1'b0;
  endtask

  task automatic test_single_i();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0000_1234;
    run_burst(0, 8'hFF, 0, -1, 4'b1000, 32'hA000_0000);
    i_req = 1'b0;
    n_tests++;
    if (got_done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b expected 1", got_done); end
    n_tests++;
    if (obs_araddr !== 32'h0000_1230) begin n_fail++; $display("FAIL single_araddr: got %h expected 00001230", obs_araddr); end
    n_tests++;
    if (first_arv != 0) begin n_fail++; $display("FAIL single_grant_lat: got %0d expected 0", first_arv); end
    n_tests++;
    if (done_cyc != 5) begin n_fail++; $display("FAIL single_burst_lat: got %0d expected 5", done_cyc); end
    n_tests++;
    if (n_beats != 4) begin n_fail++; $display("FAIL single_nbeats: got %0d expected 4", n_beats); end
    for (int b = 0; b < 4; b++) begin
      n_tests++;
      if (obs_own[b] !== 2'b10 || obs_beat[b] != b || obs_data[b] !== 32'hA000_0000 + 32'(b) ||
          obs_done[b] !== ((b == 3) ? 2'b10 : 2'b00) || obs_err[b] !== 1'b0) begin
        n_fail++;
        $display("FAIL single_beat%0d: got own=%b beat=%0d data=%h done=%b err=%b expected own=10 beat=%0d data=%h done=%b err=0",
                 b, obs_own[b], obs_beat[b], obs_data[b], obs_done[b], obs_err[b], b,
                 32'hA000_0000 + 32'(b), (b == 3) ? 2'b10 : 2'b00);
      end
    end
    n_tests++;
    if (stray != 0) begin n_fail++; $display("FAIL single_stray_done: got %0d expected 0", stray); end
    n_tests++;
    if (prot_err !== 1'b0) begin n_fail++; $display("FAIL single_prot: got %b expected 0", prot_err); end
  endtask

  task automatic test_arbitration();
    logic [1:0]  exp_own;
    logic [31:0] exp_addr;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0000_2004;
    d_req = 1'b1; d_addr = 32'h0000_3008;
    for (int b = 0; b < 3; b++) begin
`ifdef REFILL_ARB_RR_EN
      exp_own = (b == 1) ? 2'b10 : 2'b01;
`else
      exp_own = 2'b01;
`endif
      exp_addr = (exp_own == 2'b01) ? 32'h0000_3000 : 32'h0000_2000;
      run_burst(0, 8'hFF, 0, -1, 4'b1000, 32'hB000_0000 + 32'(b * 16));
      n_tests++;
      if (got_done !== 1'b1 || n_beats != 4 || obs_own[0] !== exp_own || obs_own[3] !== exp_own) begin
        n_fail++;
        $display("FAIL arb_burst%0d: got done=%b beats=%0d own=%b/%b expected done=1 beats=4 own=%b",
                 b, got_done, n_beats, obs_own[0], obs_own[3], exp_own);
      end
      n_tests++;
      if (obs_araddr !== exp_addr) begin
        n_fail++; $display("FAIL arb_addr%0d: got %h expected %h", b, obs_araddr, exp_addr);
      end
      n_tests++;
      if (first_arv != 0) begin
        n_fail++; $display("FAIL arb_turnaround%0d: got %0d expected 0", b, first_arv);
      end
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_ar_stall();
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'hABCD_EF7F;
    run_burst(5, 8'hFF, 0, -1, 4'b1000, 32'hC000_0000);
    d_req = 1'b0;
    n_tests++;
    if (arv_cnt != 6) begin n_fail++; $display("FAIL stall_arvalid_cycles: got %0d expected 6", arv_cnt); end
    n_tests++;
    if (araddr_chg !== 1'b0 || obs_araddr !== 32'hABCD_EF70) begin
      n_fail++; $display("FAIL stall_araddr: got %h changed=%b expected abcdef70 changed=0", obs_araddr, araddr_chg);
    end
    n_tests++;
    if (early_beat != 0) begin n_fail++; $display("FAIL stall_early_beat: got %0d expected 0", early_beat); end
    n_tests++;
    if (n_beats != 4 || obs_data[0] !== 32'hC000_0000 || obs_own[0] !== 2'b01) begin
      n_fail++;
      $display("FAIL stall_beats: got beats=%0d data0=%h own=%b expected beats=4 data0=c0000000 own=01",
               n_beats, obs_data[0], obs_own[0]);
    end
  endtask

  task automatic test_rvalid_gaps();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0000_0040;
    // pattern 1,0,0,1,1,0,1 (index 0 in bit 0)
    run_burst(0, 8'b0101_1001, 7, 1, 4'b1000, 32'hD000_0000);
    i_req = 1'b0;
    n_tests++;
    if (n_beats != 4 || got_done !== 1'b1) begin
      n_fail++; $display("FAIL gaps_nbeats: got %0d done=%b expected 4 done=1", n_beats, got_done);
    end
    for (int b = 0; b < 4; b++) begin
      n_tests++;
      if (obs_err[b] !== ((b == 1) ? 1'b1 : 1'b0) || obs_beat[b] != b ||
          obs_data[b] !== 32'hD000_0000 + 32'(b) || obs_done[b] !== ((b == 3) ? 2'b10 : 2'b00)) begin
        n_fail++;
        $display("FAIL gaps_beat%0d: got err=%b beat=%0d data=%h done=%b expected err=%b beat=%0d",
                 b, obs_err[b], obs_beat[b], obs_data[b], obs_done[b], (b == 1), b);
      end
    end
    n_tests++;
    if (prot_err !== 1'b0) begin n_fail++; $display("FAIL gaps_prot: got %b expected 0", prot_err); end
  endtask

  task automatic test_rlast_error();
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h0000_0080;
    run_burst(0, 8'hFF, 0, -1, 4'b1010, 32'hE000_0000);
    d_req = 1'b0;
    n_tests++;
    if (obs_prot[0] !== 1'b0 || obs_prot[1] !== 1'b1 || obs_prot[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL rlast_prot_rise: got %b%b%b expected 011", obs_prot[0], obs_prot[1], obs_prot[3]);
    end
    n_tests++;
    if (n_beats != 4 || obs_done[3] !== 2'b01 || obs_done[1] !== 2'b00) begin
      n_fail++;
      $display("FAIL rlast_done: got beats=%0d done1=%b done3=%b expected beats=4 done1=00 done3=01",
               n_beats, obs_done[1], obs_done[3]);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (prot_err !== 1'b1) begin n_fail++; $display("FAIL rlast_sticky: got %b expected 1", prot_err); end
  endtask

  task automatic test_reset_mid_burst();
    logic [11:0] ctl;
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h0000_0104; arready = 1'b1; rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hC0DE_0000; rresp = 2'd0; rlast = 1'b0;
    @(negedge clk);
    rdata = 32'hC0DE_0001;
    @(negedge clk);
    n_tests++;
    if (d_rvalid !== 1'b1 || d_beat !== 2'd1 || rdata_o !== 32'hC0DE_0001) begin
      n_fail++;
      $display("FAIL rstmid_pre: got d_rvalid=%b d_beat=%0d rdata=%h expected 1 1 c0de0001", d_rvalid, d_beat, rdata_o);
    end
    rvalid = 1'b0;
    #1 rst = 1'b1;
    #1;
    ctl = {arvalid, rready, i_rvalid, d_rvalid, i_done, d_done, i_beat, d_beat, rerr_o, prot_err};
    n_tests++;
    if (ctl !== 12'h000 || araddr !== 32'h0 || rdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_async: got ctl=%h araddr=%h rdata=%h expected all 0", ctl, araddr, rdata_o);
    end
    @(negedge clk);
    n_tests++;
    if (arvalid !== 1'b0 || rready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_held: got arvalid=%b rready=%b expected 0 0", arvalid, rready);
    end
    rst = 1'b0; d_addr = 32'h0000_0208;
    run_burst(0, 8'hFF, 0, -1, 4'b1000, 32'hF000_0000);
    d_req = 1'b0;
    n_tests++;
    if (first_arv != 0 || obs_araddr !== 32'h0000_0200) begin
      n_fail++; $display("FAIL rstmid_regrant: got lat=%0d araddr=%h expected 0 00000200", first_arv, obs_araddr);
    end
    n_tests++;
    if (n_beats != 4 || obs_beat[0] != 0 || obs_beat[3] != 3 || obs_own[0] !== 2'b01 || obs_done[3] !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid_burst: got beats=%0d b0=%0d b3=%0d own=%b done3=%b expected 4 0 3 01 01",
               n_beats, obs_beat[0], obs_beat[3], obs_own[0], obs_done[3]);
    end
    n_tests++;
    if (prot_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_prot: got %b expected 0", prot_err); end
  endtask

  initial begin
    test_reset();
    test_single_i();
    test_arbitration();
    test_ar_stall();
    test_rvalid_gaps();
    test_rlast_error();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
